// File: rtl/cronometro_pkg.sv
// Shared definitions for the countdown timer: state codes, BCD digit limits,
// segment constants and the BCD mm:ss helpers.
package cronometro_pkg;

  localparam logic [1:0] PARADO   = 2'd0;
  localparam logic [1:0] CONTANDO = 2'd1;
  localparam logic [1:0] PAUSADO  = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_ZERO = 7'b0111111;

  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[15:12] <= DIGIT_MAX) && (v[11:8] <= DIGIT_MAX) &&
           (v[7:4] <= SEC_TENS_MAX) && (v[3:0] <= DIGIT_MAX);
  endfunction

  // One-second BCD decrement with borrow; 00:00 saturates.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = v;
    if (v != 16'h0000) begin
      if (su != 4'd0) begin
        su = su - 4'd1;
      end else begin
        su = DIGIT_MAX;
        if (st != 4'd0) begin
          st = st - 4'd1;
        end else begin
          st = SEC_TENS_MAX;
          if (mu != 4'd0) begin
            mu = mu - 4'd1;
          end else begin
            mu = DIGIT_MAX;
            mt = mt - 4'd1;
          end
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

endpackage

// File: rtl/display.sv
// Combinational BCD to 7-segment encoder; codes above 9 blank the digit.
module display
  import cronometro_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] seg
);

  always_comb begin
    case (digito)
      4'd0:    seg = SEG_ZERO;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/cronometro_regressivo.sv
// mm:ss countdown timer with load/start/pause/stop buttons, BCD count,
// registered 7-segment outputs and an end-of-count alarm.
module cronometro_regressivo
  import cronometro_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        carregarI,
  input  logic        contarI,
  input  logic        pausarI,
  input  logic        pararI,
  input  logic [15:0] valor_carga,
  output logic [6:0]  display_mss,
  output logic [6:0]  display_uss,
  output logic [6:0]  display_dss,
  output logic [6:0]  display_css,
  output logic        alarme,
  output logic        erro
);

  localparam int              PW         = $clog2(DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

  logic [3:0]    btn, pulse;
  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   count_q, count_d, preset_q, preset_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          erro_q, erro_d;
  logic [6:0]    seg_mss_c, seg_uss_c, seg_dss_c, seg_css_c;
  logic [6:0]    seg_mss_q, seg_uss_q, seg_dss_q, seg_css_q;
  logic [6:0]    seg_mss_d, seg_uss_d, seg_dss_d, seg_css_d;
  logic          sel_parar, sel_carga, sel_contar, sel_pausar;

  // Bit order {parar, carregar, contar, pausar} doubles as the priority order.
  assign btn = {pararI, carregarI, contarI, pausarI};

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    pulse   = sync2_q & ~edge_q;

    sel_parar  = pulse[3];
    sel_carga  = ~pulse[3] & pulse[2];
    sel_contar = ~pulse[3] & ~pulse[2] & pulse[1];
    sel_pausar = ~pulse[3] & ~pulse[2] & ~pulse[1] & pulse[0];
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    presc_d  = presc_q;
    erro_d   = 1'b0;

    if (sel_parar) begin
      count_d = preset_q;
      presc_d = '0;
      state_d = PARADO;
    end else if (sel_carga && (state_q == PARADO || state_q == FIM)) begin
      if (bcd_valid(valor_carga)) begin
        preset_d = valor_carga;
        count_d  = valor_carga;
        presc_d  = '0;
        state_d  = PARADO;
      end else begin
        erro_d = 1'b1;
      end
    end else if (sel_contar && state_q == PARADO && count_q != 16'h0000) begin
      presc_d = '0;
      state_d = CONTANDO;
    end else if (sel_contar && state_q == PAUSADO) begin
      state_d = CONTANDO;
    end else if (sel_pausar && state_q == CONTANDO) begin
      state_d = PAUSADO;
    end else if (state_q == CONTANDO) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        count_d = bcd_dec(count_q);
        if (count_d == 16'h0000) state_d = FIM;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  display u_dig_mss (.digito(count_q[3:0]),   .seg(seg_mss_c));
  display u_dig_uss (.digito(count_q[7:4]),   .seg(seg_uss_c));
  display u_dig_dss (.digito(count_q[11:8]),  .seg(seg_dss_c));
  display u_dig_css (.digito(count_q[15:12]), .seg(seg_css_c));

  always_comb begin
    seg_mss_d = seg_mss_c;
    seg_uss_d = seg_uss_c;
    seg_dss_d = seg_dss_c;
    seg_css_d = seg_css_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      edge_q    <= '0;
      state_q   <= PARADO;
      count_q   <= '0;
      preset_q  <= '0;
      presc_q   <= '0;
      erro_q    <= 1'b0;
      seg_mss_q <= SEG_ZERO;
      seg_uss_q <= SEG_ZERO;
      seg_dss_q <= SEG_ZERO;
      seg_css_q <= SEG_ZERO;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      edge_q    <= edge_d;
      state_q   <= state_d;
      count_q   <= count_d;
      preset_q  <= preset_d;
      presc_q   <= presc_d;
      erro_q    <= erro_d;
      seg_mss_q <= seg_mss_d;
      seg_uss_q <= seg_uss_d;
      seg_dss_q <= seg_dss_d;
      seg_css_q <= seg_css_d;
    end
  end

  assign display_mss = seg_mss_q;
  assign display_uss = seg_uss_q;
  assign display_dss = seg_dss_q;
  assign display_css = seg_css_q;
  assign alarme      = (state_q == FIM);
  assign erro        = erro_q;

endmodule

// File: tb/tb_cronometro_regressivo.sv
// Bench for cronometro_regressivo: directed scenarios plus random button
// traffic, checked every cycle against a seconds-based reference model.
module tb_cronometro_regressivo;

  localparam int DIV = 4;
  localparam int S_STOP = 0, S_RUN = 1, S_PAUSE = 2, S_END = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        carregarI = 1'b0, contarI = 1'b0, pausarI = 1'b0, pararI = 1'b0;
  logic [15:0] valor_carga = 16'h0000;
  logic [6:0]  display_mss, display_uss, display_dss, display_css;
  logic        alarme, erro;

  int errors = 0;
  int checks = 0;

  // Reference model: count and preset as plain seconds.
  int   m_secs, m_preset, m_presc, m_shown, m_state;
  logic m_err;
  int   cd [4];
  int   erro_seen;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  cronometro_regressivo #(.DIV(DIV)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .carregarI  (carregarI),
    .contarI    (contarI),
    .pausarI    (pausarI),
    .pararI     (pararI),
    .valor_carga(valor_carga),
    .display_mss(display_mss),
    .display_uss(display_uss),
    .display_dss(display_dss),
    .display_css(display_css),
    .alarme     (alarme),
    .erro       (erro)
  );

  always #5 clock = ~clock;

  function automatic int bcd_to_secs(input logic [15:0] v);
    int mn, sc;
    mn = int'(v[15:12]) * 10 + int'(v[11:8]);
    sc = int'(v[7:4]) * 10 + int'(v[3:0]);
    return mn * 60 + sc;
  endfunction

  function automatic logic load_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [27:0] segs_of(input int s);
    int mn, sc;
    mn = s / 60;
    sc = s % 60;
    return {seg_tab[mn / 10], seg_tab[mn % 10], seg_tab[sc / 10], seg_tab[sc % 10]};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_preset = 0; m_presc = 0; m_shown = 0; m_state = S_STOP; m_err = 1'b0;
    for (int b = 0; b < 4; b++) cd[b] = 0;
  endtask

  // cd index: 0 parar, 1 carregar, 2 contar, 3 pausar
  task automatic model_step();
    bit f [4];
    m_shown = m_secs;
    m_err   = 1'b0;
    for (int b = 0; b < 4; b++) begin
      f[b] = 1'b0;
      if (cd[b] > 0) begin
        cd[b]--;
        if (cd[b] == 0) f[b] = 1'b1;
      end
    end
    if (f[0]) begin
      m_secs = m_preset; m_presc = 0; m_state = S_STOP;
    end else if (f[1] && (m_state == S_STOP || m_state == S_END)) begin
      if (load_ok(valor_carga)) begin
        m_preset = bcd_to_secs(valor_carga); m_secs = m_preset; m_presc = 0; m_state = S_STOP;
      end else begin
        m_err = 1'b1;
      end
    end else if (!f[1] && f[2] && m_state == S_STOP && m_secs != 0) begin
      m_state = S_RUN; m_presc = 0;
    end else if (!f[1] && f[2] && m_state == S_PAUSE) begin
      m_state = S_RUN;
    end else if (!f[1] && !f[2] && f[3] && m_state == S_RUN) begin
      m_state = S_PAUSE;
    end else if (m_state == S_RUN) begin
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_secs--;
        if (m_secs == 0) m_state = S_END;
      end else begin
        m_presc++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk(tag, {2'b00, display_css, display_dss, display_uss, display_mss, alarme, erro},
        {2'b00, segs_of(m_shown), (m_state == S_END), m_err});
  endtask

  task automatic chk_disp(input string tag, input logic [15:0] bcd);
    chk(tag, {4'h0, display_css, display_dss, display_uss, display_mss},
        {4'h0, seg_tab[bcd[15:12]], seg_tab[bcd[11:8]], seg_tab[bcd[7:4]], seg_tab[bcd[3:0]]});
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    if (erro === 1'b1) erro_seen++;
    chk_model("cycle");
  endtask

  // m bits: 0 parar, 1 carregar, 2 contar, 3 pausar
  task automatic press(input logic [3:0] m);
    if (m[0]) begin pararI    = 1'b1; cd[0] = 3; end
    if (m[1]) begin carregarI = 1'b1; cd[1] = 3; end
    if (m[2]) begin contarI   = 1'b1; cd[2] = 3; end
    if (m[3]) begin pausarI   = 1'b1; cd[3] = 3; end
    repeat (3) cycle();
    pararI = 1'b0; carregarI = 1'b0; contarI = 1'b0; pausarI = 1'b0;
    cycle();
  endtask

  initial begin
    model_reset();
    erro_seen = 0;

    // Reset without any clock edge
    #1 reset_n = 1'b0;
    #1;
    chk_disp("reset_digits", 16'h0000);
    chk("reset_alarme", {31'd0, alarme}, 32'd0);
    chk("reset_erro", {31'd0, erro}, 32'd0);
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (3) cycle();

    // Load 01:05 and count
    valor_carga = 16'h0105;
    press(4'b0010);
    chk_disp("load_0105", 16'h0105);
    press(4'b0100);
    repeat (20) cycle();
    chk_disp("five_ticks", 16'h0100);
    repeat (4) cycle();
    chk_disp("tick_0059", 16'h0059);
    repeat (3) cycle();
    chk_disp("hold_0059", 16'h0059);
    cycle();
    chk_disp("tick_0058", 16'h0058);

    // Count to zero, alarm, ignored contar, parar restores preset
    press(4'b0001);
    chk_disp("parar_0105", 16'h0105);
    valor_carga = 16'h0002;
    press(4'b0010);
    press(4'b0100);
    repeat (7) cycle();
    chk("alarm_rise", {31'd0, alarme}, 32'd1);
    cycle();
    chk_disp("fim_0000", 16'h0000);
    press(4'b0100);
    chk("fim_hold_alarme", {31'd0, alarme}, 32'd1);
    chk_disp("fim_hold_digits", 16'h0000);
    press(4'b0001);
    chk_disp("fim_parar", 16'h0002);
    chk("fim_parar_alarme", {31'd0, alarme}, 32'd0);

    // Pause at 00:45, resume with partial prescaler
    valor_carga = 16'h0050;
    press(4'b0010);
    press(4'b0100);
    repeat (18) cycle();
    press(4'b1000);
    chk_disp("paused_0045", 16'h0045);
    repeat (40) cycle();
    chk_disp("paused_40", 16'h0045);
    press(4'b0100);
    repeat (2) cycle();
    chk_disp("resume_wait", 16'h0045);
    cycle();
    chk_disp("resume_partial", 16'h0044);

    // Rejected load and parar beating carregar
    press(4'b0001);
    valor_carga = 16'h0160;
    erro_seen = 0;
    press(4'b0010);
    chk("erro_one_cycle", erro_seen, 32'd1);
    chk_disp("bad_load_keep", 16'h0050);
    valor_carga = 16'h0130;
    press(4'b0011);
    chk_disp("parar_wins", 16'h0050);

    // Random button traffic
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)
        valor_carga = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      else if (r == 4)
        valor_carga = 16'($urandom);
      if (r < 6) press(4'b0001 << $urandom_range(0, 3));
      else       press(4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 30)) cycle();
    end

    // Asynchronous reset mid-count
    press(4'b0001);
    valor_carga = 16'h0010;
    press(4'b0010);
    press(4'b0100);
    repeat (6) cycle();
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    chk_disp("async_rst_digits", 16'h0000);
    chk("async_rst_alarme", {31'd0, alarme}, 32'd0);
    cycle();
    reset_n = 1'b1;
    repeat (3) cycle();
    press(4'b0100);
    repeat (8) cycle();
    chk_disp("post_rst_idle", 16'h0000);
    chk("post_rst_alarme", {31'd0, alarme}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
